fft_bfii: RTL and testbench

- Radix-2² SDF butterfly type II. Sits directly downstream of the type-I butterfly (fft_bfi) in each radix-2² FFT stage.
- Consumes the type-I output, performs the add/subtract with an integrated trivial -j rotation, and stores half a butterfly in a feedback delay line of SHIFT_REG_LEN samples.
- Forwards the stage-valid carry, aligned to its registered outputs.

---
 rtl/fft_bfii.sv | 136 +++++++++++++
 tb/tb_fft_bfii.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fft_bfii.sv
// Radix-2^2 SDF butterfly type II: add/subtract with an optional trivial -j
// rotation, a SHIFT_REG_LEN-deep feedback delay line, and a carry line that
// keeps the valid flag aligned with the registered outputs.
module fft_bfii #(
    parameter int unsigned WIDTH         = 25,
    parameter int unsigned SHIFT_REG_LEN = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carry_in,
    output logic             carry_out,
    input  logic             sel_i,
    input  logic             tw_i,
    input  logic [WIDTH-1:0] x_re_i,
    input  logic [WIDTH-1:0] x_im_i,
    output logic [WIDTH-1:0] z_re_o,
    output logic [WIDTH-1:0] z_im_o
);

    logic [WIDTH-1:0] x_rot_re, x_rot_im;
    logic [WIDTH-1:0] sr_re, sr_im;
    logic [WIDTH-1:0] dl_in_re, dl_in_im;
    logic [WIDTH-1:0] z_re_d, z_re_q, z_im_d, z_im_q;
    logic [SHIFT_REG_LEN-1:0] carry_d, carry_q;
    logic carry_out_d, carry_out_q;

    // Rotation, butterfly add/subtract and delay-line input; all arithmetic wraps.
    always_comb begin
        x_rot_re = x_re_i;
        x_rot_im = x_im_i;
        if (sel_i && tw_i) begin
            x_rot_re = x_im_i;
            x_rot_im = '0 - x_re_i;
        end
        if (sel_i) begin
            z_re_d   = sr_re + x_rot_re;
            z_im_d   = sr_im + x_rot_im;
            dl_in_re = sr_re - x_rot_re;
            dl_in_im = sr_im - x_rot_im;
        end else begin
            z_re_d   = sr_re;
            z_im_d   = sr_im;
            dl_in_re = x_re_i;
            dl_in_im = x_im_i;
        end
    end

    // Carry line: SHIFT_REG_LEN stages here plus the output register.
    always_comb begin
        carry_d     = carry_q << 1;
        carry_d[0]  = carry_in;
        carry_out_d = carry_q[SHIFT_REG_LEN-1];
    end

    // Output and carry registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_re_q      <= '0;
            z_im_q      <= '0;
            carry_q     <= '0;
            carry_out_q <= 1'b0;
        end else begin
            z_re_q      <= z_re_d;
            z_im_q      <= z_im_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign z_re_o    = z_re_q;
    assign z_im_o    = z_im_q;
    assign carry_out = carry_out_q;

    if (SHIFT_REG_LEN > 32) begin : g_ram
        // Long lines: circular RAM buffer, data not reset (carry line tracks validity).
        localparam int unsigned PtrW = $clog2(SHIFT_REG_LEN);
        logic [WIDTH-1:0] mem_re_q [SHIFT_REG_LEN];
        logic [WIDTH-1:0] mem_im_q [SHIFT_REG_LEN];
        logic [PtrW-1:0]  ptr_d, ptr_q;

        // Pointer wraps after SHIFT_REG_LEN slots, so a read sees the write from that many cycles ago.
        always_comb begin
            ptr_d = (ptr_q == PtrW'(SHIFT_REG_LEN - 1)) ? '0 : ptr_q + PtrW'(1);
        end

        // Read pointer register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) ptr_q <= '0;
            else     ptr_q <= ptr_d;
        end

        // Read-before-write of the same slot every cycle.
        always_ff @(posedge clk) begin
            mem_re_q[ptr_q] <= dl_in_re;
            mem_im_q[ptr_q] <= dl_in_im;
        end

        assign sr_re = mem_re_q[ptr_q];
        assign sr_im = mem_im_q[ptr_q];
    end else begin : g_reg
        // Short lines: resettable register shift chain.
        logic [WIDTH-1:0] sh_re_d [SHIFT_REG_LEN];
        logic [WIDTH-1:0] sh_re_q [SHIFT_REG_LEN];
        logic [WIDTH-1:0] sh_im_d [SHIFT_REG_LEN];
        logic [WIDTH-1:0] sh_im_q [SHIFT_REG_LEN];

        // Shift by one stage, new sample enters at index 0.
        always_comb begin
            sh_re_d[0] = dl_in_re;
            sh_im_d[0] = dl_in_im;
            for (int i = 1; i < SHIFT_REG_LEN; i++) begin
                sh_re_d[i] = sh_re_q[i-1];
                sh_im_d[i] = sh_im_q[i-1];
            end
        end

        // Delay chain state, cleared asynchronously.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < SHIFT_REG_LEN; i++) begin
                    sh_re_q[i] <= '0;
                    sh_im_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < SHIFT_REG_LEN; i++) begin
                    sh_re_q[i] <= sh_re_d[i];
                    sh_im_q[i] <= sh_im_d[i];
                end
            end
        end

        assign sr_re = sh_re_q[SHIFT_REG_LEN-1];
        assign sr_im = sh_im_q[SHIFT_REG_LEN-1];
    end

endmodule

// File: tb/tb_fft_bfii.sv
// Bench for fft_bfii (WIDTH=8, SHIFT_REG_LEN=2): directed steps plus random
// traffic compared against a queue-based butterfly model.
module tb_fft_bfii;

    localparam int unsigned W = 8;
    localparam int unsigned L = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         carry_in = 1'b0;
    logic         carry_out;
    logic         sel_i = 1'b0;
    logic         tw_i = 1'b0;
    logic [W-1:0] x_re_i = '0;
    logic [W-1:0] x_im_i = '0;
    logic [W-1:0] z_re_o;
    logic [W-1:0] z_im_o;

    fft_bfii #(.WIDTH(W), .SHIFT_REG_LEN(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (carry_in),
        .carry_out (carry_out),
        .sel_i     (sel_i),
        .tw_i      (tw_i),
        .x_re_i    (x_re_i),
        .x_im_i    (x_im_i),
        .z_re_o    (z_re_o),
        .z_im_o    (z_im_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model state: delay-line contents in arrival order, carry history.
    logic [W-1:0] dq_re[$];
    logic [W-1:0] dq_im[$];
    logic         cq[$];
    logic [W-1:0] exp_re, exp_im;
    logic         exp_c;

    function automatic logic [W-1:0] s8(int v);
        return v[W-1:0];
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
    endtask

    task automatic model_reset();
        dq_re.delete(); dq_im.delete(); cq.delete();
        for (int i = 0; i < L; i++) begin
            dq_re.push_back('0); dq_im.push_back('0); cq.push_back(1'b0);
        end
        exp_re = '0; exp_im = '0; exp_c = 1'b0;
    endtask

    // One clock: drive at negedge, update model at posedge, check #1 later.
    task automatic step(logic sel, logic tw, int xr, int xi, logic cin);
        logic [W-1:0] a_re, a_im, r_re, r_im, s_re, s_im;
        @(negedge clk);
        sel_i = sel; tw_i = tw; x_re_i = s8(xr); x_im_i = s8(xi); carry_in = cin;
        @(posedge clk);
        a_re = s8(xr); a_im = s8(xi);
        s_re = dq_re.pop_front(); s_im = dq_im.pop_front();
        if (sel && tw) begin
            r_re = a_im; r_im = s8(-xr);
        end else begin
            r_re = a_re; r_im = a_im;
        end
        if (sel) begin
            exp_re = s_re + r_re; exp_im = s_im + r_im;
            dq_re.push_back(s_re - r_re); dq_im.push_back(s_im - r_im);
        end else begin
            exp_re = s_re; exp_im = s_im;
            dq_re.push_back(a_re); dq_im.push_back(a_im);
        end
        cq.push_back(cin);
        exp_c = cq.pop_front();
        #1;
        chk("z_re", z_re_o, exp_re);
        chk("z_im", z_im_o, exp_im);
        chk("carry", {7'b0, carry_out}, {7'b0, exp_c});
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_z_re", z_re_o, '0);
        chk("rst_z_im", z_im_o, '0);
        chk("rst_carry", {7'b0, carry_out}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill then compute
        step(1'b0, 1'b0, 1, 2, 1'b0);
        step(1'b0, 1'b0, 3, 4, 1'b0);
        step(1'b1, 1'b0, 10, 20, 1'b0);
        chk("fc_sum0_re", z_re_o, s8(11));  chk("fc_sum0_im", z_im_o, s8(22));
        step(1'b1, 1'b0, 30, 40, 1'b0);
        chk("fc_sum1_re", z_re_o, s8(33));  chk("fc_sum1_im", z_im_o, s8(44));
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("fc_dif0_re", z_re_o, s8(-9));  chk("fc_dif0_im", z_im_o, s8(-18));
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("fc_dif1_re", z_re_o, s8(-27)); chk("fc_dif1_im", z_im_o, s8(-36));

        // Rotation
        step(1'b0, 1'b0, 1, 2, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 10, 20, 1'b0);
        chk("rot_sum_re", z_re_o, s8(21));  chk("rot_sum_im", z_im_o, s8(-8));
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("rot_dif_re", z_re_o, s8(-19)); chk("rot_dif_im", z_im_o, s8(12));

        // Wrap-around
        step(1'b0, 1'b0, 100, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 100, 0, 1'b0);
        chk("wrap_add_re", z_re_o, s8(-56));
        step(1'b1, 1'b1, -128, 0, 1'b0);
        chk("wrap_neg_re", z_re_o, s8(0));  chk("wrap_neg_im", z_im_o, s8(-128));
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);

        // tw ignored in fill phase
        step(1'b0, 1'b1, 5, 6, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("twign_re", z_re_o, s8(5));     chk("twign_im", z_im_o, s8(6));

        // Single carry pulse: visible only in cycle 3
        step(1'b0, 1'b0, 0, 0, 1'b1);
        chk("pulse_c1", {7'b0, carry_out}, 8'd0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("pulse_c2", {7'b0, carry_out}, 8'd0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("pulse_c3", {7'b0, carry_out}, 8'd1);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("pulse_c4", {7'b0, carry_out}, 8'd0);

        // Continuous carry
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, i, -i, 1'b1);
            if (i >= 2) chk("cont_c", {7'b0, carry_out}, 8'd1);
        end

        // Async reset mid-stream with a fresh carry in flight
        step(1'b1, 1'b0, 50, 50, 1'b0);
        step(1'b1, 1'b0, 9, 9, 1'b0);
        step(1'b1, 1'b0, 7, 3, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_z_re", z_re_o, '0);
        chk("arst_z_im", z_im_o, '0);
        chk("arst_carry", {7'b0, carry_out}, 8'd0);
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 0, 0, 1'b0);
            chk("arst_no_carry", {7'b0, carry_out}, 8'd0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
